pipe_ctrl: RTL and testbench

//  Hazard/stall/flush controller for the 5-stage pipeline. Tracks in-flight

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_ctrl_hazard_cmp.sv | 60 ++++++
 rtl/pipe_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline hazard/stall/flush controller.
//   NOP_OP          : opcode the datapath loads into D/E or E/M op on a bubble
//   state_e         : controller FSM states (RUN, STALL, MWAIT, REDIR)
//   FWD_REG..FWD_W  : operand-source select codes driven on fwd_s / fwd_t
// Optional feature macro used by the files importing this package:
//   PIPE_CTRL_FWD_EN (operand forwarding; undefined = full scoreboard stalls)
package pipe_pkg;

    localparam logic [5:0] NOP_OP = 6'b110111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        MWAIT = 2'd2,
        REDIR = 2'd3
    } state_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// hazard_cmp -- compares one decode source register against the E/M/W
// destination scoreboard.
//   id_valid  in  1  decode stage holds a real instruction
//   src       in  5  decode source register (0 = no dependency)
//   wreg_e/m/w in 5  in-flight destination registers (0 = empty slot)
//   load_e    in  1  instruction in E is a load
//   hit       out 1  this source must stall decode
//   fwd_sel   out 2  operand source select (FWD_* codes)
// Macro PIPE_CTRL_FWD_EN: when defined only a load in E stalls and the newest
// matching stage is selected for forwarding; otherwise any match stalls and
// fwd_sel stays FWD_REG.
module hazard_cmp
    import pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] src,
    input  logic [4:0] wreg_e,
    input  logic [4:0] wreg_m,
    input  logic [4:0] wreg_w,
    input  logic       load_e,
    output logic       hit,
    output logic [1:0] fwd_sel
);

    logic match_e;
    logic match_m;
    logic match_w;

    // Register 0 never creates a dependency, so gate every match with src!=0.
    always_comb begin
        match_e = (src != 5'd0) && (src == wreg_e);
        match_m = (src != 5'd0) && (src == wreg_m);
        match_w = (src != 5'd0) && (src == wreg_w);
    end

`ifdef PIPE_CTRL_FWD_EN
    always_comb begin
        hit = id_valid && match_e && load_e;
        // Newest producer wins: E holds the youngest value.
        if (match_e) begin
            fwd_sel = FWD_E;
        end else if (match_m) begin
            fwd_sel = FWD_M;
        end else if (match_w) begin
            fwd_sel = FWD_W;
        end else begin
            fwd_sel = FWD_REG;
        end
    end
`else
    logic unused_load_e;

    always_comb begin
        hit           = id_valid && (match_e || match_m || match_w);
        fwd_sel       = FWD_REG;
        unused_load_e = load_e;
    end
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard/stall/flush controller for the 5-stage pipeline.
// Keeps an E/M/W destination-register scoreboard, stalls decode on RAW hazards,
// freezes the whole pipe while data memory is busy and flushes wrong-path work
// after a taken branch/jump resolved in E.
//   clk, rstd                  clock (rising edge), async active-low reset
//   id_valid,id_rs,id_rt       decode instruction and its source registers
//   id_wreg,id_load            decode destination register / is-load flag
//   ex_redirect, dm_busy       redirect from E, data memory not ready
//   pc_we,fd_we,fd_flush       PC and F/D controls
//   de_we,de_bub,em_we,em_bub  D/E and E/M enables / NOP_OP bubble loads
//   mw_we                      M/W enable (also advances the scoreboard)
//   fwd_s,fwd_t                operand source select (forwarding build only)
//   stall_cycles               saturating count of non-RUN behaviour cycles
// Macro PIPE_CTRL_FWD_EN enables forwarding (load-use stalls only).
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REDIR_CYC = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_wreg,
    input  logic             id_load,
    input  logic             ex_redirect,
    input  logic             dm_busy,
    output logic             pc_we,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             de_we,
    output logic             de_bub,
    output logic             em_we,
    output logic             em_bub,
    output logic             mw_we,
    output logic [1:0]       fwd_s,
    output logic [1:0]       fwd_t,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] REDIR_LOAD = 3'(REDIR_CYC);

    state_e            state_q, state_d;
    state_e            saved_q, saved_d;
    state_e            eff_state;
    logic [2:0]        redir_cnt_q, redir_cnt_d;
    logic [4:0]        wreg_e_q, wreg_e_d;
    logic [4:0]        wreg_m_q, wreg_m_d;
    logic [4:0]        wreg_w_q, wreg_w_d;
    logic              load_e_q, load_e_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    logic              hit_s, hit_t, hazard;
    logic [1:0]        fwd_s_c, fwd_t_c;
    logic              pc_we_c, fd_we_c, fd_flush_c, de_we_c, de_bub_c;
    logic              em_we_c, em_bub_c, mw_we_c;

    hazard_cmp u_cmp_rs (
        .id_valid (id_valid),
        .src      (id_rs),
        .wreg_e   (wreg_e_q),
        .wreg_m   (wreg_m_q),
        .wreg_w   (wreg_w_q),
        .load_e   (load_e_q),
        .hit      (hit_s),
        .fwd_sel  (fwd_s_c)
    );

    hazard_cmp u_cmp_rt (
        .id_valid (id_valid),
        .src      (id_rt),
        .wreg_e   (wreg_e_q),
        .wreg_m   (wreg_m_q),
        .wreg_w   (wreg_w_q),
        .load_e   (load_e_q),
        .hit      (hit_t),
        .fwd_sel  (fwd_t_c)
    );

    assign hazard = hit_s || hit_t;

    // Leaving MWAIT the controller behaves as the state it was frozen in, in
    // the same cycle dm_busy drops (no extra recovery cycle).
    assign eff_state = (state_q == MWAIT) ? saved_q : state_q;

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        redir_cnt_d = redir_cnt_q;
        pc_we_c     = 1'b1;
        fd_we_c     = 1'b1;
        fd_flush_c  = 1'b0;
        de_we_c     = 1'b1;
        de_bub_c    = 1'b0;
        em_we_c     = 1'b1;
        em_bub_c    = 1'b0;
        mw_we_c     = 1'b1;

        if (dm_busy) begin
            pc_we_c = 1'b0;
            fd_we_c = 1'b0;
            de_we_c = 1'b0;
            em_we_c = 1'b0;
            mw_we_c = 1'b0;
            state_d = MWAIT;
            if (state_q != MWAIT) begin
                saved_d = state_q;
            end
        end else if (ex_redirect) begin
            // Wrong-path instruction in D is killed; any pending stall is moot.
            fd_flush_c  = 1'b1;
            de_bub_c    = 1'b1;
            state_d     = REDIR;
            redir_cnt_d = REDIR_LOAD;
        end else if (eff_state == REDIR) begin
            fd_flush_c = 1'b1;
            if (redir_cnt_q <= 3'd1) begin
                state_d     = RUN;
                redir_cnt_d = 3'd0;
            end else begin
                state_d     = REDIR;
                redir_cnt_d = redir_cnt_q - 3'd1;
            end
        end else if (hazard) begin
            pc_we_c  = 1'b0;
            fd_we_c  = 1'b0;
            de_bub_c = 1'b1;
            state_d  = STALL;
        end else begin
            state_d = RUN;
        end
    end

    // Scoreboard advances with the M/W register; a bubble enters E as "no dest".
    always_comb begin
        wreg_e_d = wreg_e_q;
        wreg_m_d = wreg_m_q;
        wreg_w_d = wreg_w_q;
        load_e_d = load_e_q;
        if (mw_we_c) begin
            wreg_w_d = wreg_m_q;
            wreg_m_d = wreg_e_q;
            wreg_e_d = de_bub_c ? 5'd0 : id_wreg;
            load_e_d = de_bub_c ? 1'b0 : id_load;
        end
    end

    // A cycle is counted whenever the controller is not doing plain RUN work:
    // PC held (stall or memory wait) or the fetch path is being flushed.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((!pc_we_c || fd_flush_c) && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q        <= RUN;
            saved_q        <= RUN;
            redir_cnt_q    <= 3'd0;
            wreg_e_q       <= 5'd0;
            wreg_m_q       <= 5'd0;
            wreg_w_q       <= 5'd0;
            load_e_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            saved_q        <= saved_d;
            redir_cnt_q    <= redir_cnt_d;
            wreg_e_q       <= wreg_e_d;
            wreg_m_q       <= wreg_m_d;
            wreg_w_q       <= wreg_w_d;
            load_e_q       <= load_e_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // While reset is held the pipe registers are frozen and load bubbles.
    always_comb begin
        pc_we        = rstd && pc_we_c;
        fd_we        = rstd && fd_we_c;
        fd_flush     = !rstd || fd_flush_c;
        de_we        = rstd && de_we_c;
        de_bub       = !rstd || de_bub_c;
        em_we        = rstd && em_we_c;
        em_bub       = !rstd || em_bub_c;
        mw_we        = rstd && mw_we_c;
        fwd_s        = rstd ? fwd_s_c : FWD_REG;
        fwd_t        = rstd ? fwd_t_c : FWD_REG;
        stall_cycles = stall_cycles_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl. A behavioural model
// (scoreboard as a 3-entry array, redirect as a countdown of remaining flush
// cycles, memory wait as "nothing moves") predicts every output each cycle;
// directed sequences pin the model with hand-computed values, then random
// traffic follows. Works with or without PIPE_CTRL_FWD_EN defined.
module tb_pipe_ctrl;

    localparam int REDIR_CYC = 2;
    localparam int CNT_W     = 5;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    // Control vector order: {pc_we,fd_we,fd_flush,de_we,de_bub,em_we,em_bub,mw_we}
    localparam logic [7:0] V_RUN    = 8'b1101_0101;
    localparam logic [7:0] V_STALL  = 8'b0001_1101;
    localparam logic [7:0] V_MWAIT  = 8'b0000_0000;
    localparam logic [7:0] V_RENTRY = 8'b1111_1101;
    localparam logic [7:0] V_RHOLD  = 8'b1111_0101;
    localparam logic [7:0] V_RESET  = 8'b0010_1010;

    logic             clk = 1'b0;
    logic             rstd = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs = '0, id_rt = '0, id_wreg = '0;
    logic             id_load = 1'b0, ex_redirect = 1'b0, dm_busy = 1'b0;
    logic             pc_we, fd_we, fd_flush, de_we, de_bub, em_we, em_bub, mw_we;
    logic [1:0]       fwd_s, fwd_t;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_ctrl #(.REDIR_CYC(REDIR_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstd(rstd), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_wreg(id_wreg), .id_load(id_load), .ex_redirect(ex_redirect),
        .dm_busy(dm_busy), .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush),
        .de_we(de_we), .de_bub(de_bub), .em_we(em_we), .em_bub(em_bub),
        .mw_we(mw_we), .fwd_s(fwd_s), .fwd_t(fwd_t), .stall_cycles(stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int sb[3];          // destination regs in flight: [0]=E [1]=M [2]=W
    bit ld_e;
    int redir_left;     // flush cycles still owed after a redirect
    int cnt;
    int cyc = 0;

    function automatic bit src_hits(int src);
        if (!id_valid || src == 0) return 1'b0;
`ifdef PIPE_CTRL_FWD_EN
        return ld_e && (sb[0] == src);
`else
        for (int i = 0; i < 3; i++) if (sb[i] == src) return 1'b1;
        return 1'b0;
`endif
    endfunction

    function automatic int fwd_of(int src);
`ifdef PIPE_CTRL_FWD_EN
        if (src == 0) return 0;
        for (int i = 0; i < 3; i++) if (sb[i] == src) return i + 1;
`endif
        return 0;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstd) begin
                sb = '{0, 0, 0};
                ld_e = 1'b0;
                redir_left = 0;
                cnt = 0;
                chk("rst_ctl", {pc_we, fd_we, fd_flush, de_we, de_bub, em_we, em_bub, mw_we}, V_RESET);
                chk("rst_cnt", stall_cycles, 0);
                $display("cyc %0d reset", cyc);
            end else begin
                logic [7:0] exp_v;
                int new_e;
                bit moves;
                string cls;
                moves = 1'b1;
                new_e = id_wreg;
                if (dm_busy) begin
                    exp_v = V_MWAIT; moves = 1'b0; cls = "MWAIT";
                end else if (ex_redirect) begin
                    exp_v = V_RENTRY; new_e = 0; redir_left = REDIR_CYC; cls = "REDIR0";
                end else if (redir_left > 0) begin
                    exp_v = V_RHOLD; redir_left--; cls = "REDIR";
                end else if (src_hits(id_rs) || src_hits(id_rt)) begin
                    exp_v = V_STALL; new_e = 0; cls = "STALL";
                end else begin
                    exp_v = V_RUN; cls = "RUN";
                end
                chk("ctl", {pc_we, fd_we, fd_flush, de_we, de_bub, em_we, em_bub, mw_we}, exp_v);
                chk("fwd_s", fwd_s, fwd_of(id_rs));
                chk("fwd_t", fwd_t, fwd_of(id_rt));
                chk("stall_cycles", stall_cycles, cnt);
                $display("cyc %0d %s rs=%0d rt=%0d wr=%0d sb=%0d/%0d/%0d ctl=%b cnt=%0d",
                         cyc, cls, id_rs, id_rt, id_wreg, sb[0], sb[1], sb[2], exp_v, cnt);
                if ((exp_v[7] == 1'b0 || exp_v[5] == 1'b1) && cnt < CNT_MAX) cnt++;
                if (moves) begin
                    ld_e  = (new_e == 0 && exp_v[3]) ? 1'b0 : id_load;
                    sb[2] = sb[1];
                    sb[1] = sb[0];
                    sb[0] = new_e;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int rs, input int rt, input int wr,
                         input bit ld, input bit rd, input bit busy);
        @(posedge clk);
        #1;
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_wreg = 5'(wr);
        id_load = ld; ex_redirect = rd; dm_busy = busy;
    endtask

    // Reset asserted and checked away from any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rstd = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_wreg = 0; id_load = 0;
        ex_redirect = 0; dm_busy = 0;
        #1;
        chk("async_pc_we", pc_we, 0);
        chk("async_mw_we", mw_we, 0);
        chk("async_de_bub", de_bub, 1);
        chk("async_em_bub", em_bub, 1);
        chk("async_cnt", stall_cycles, 0);
        @(posedge clk);
        #1;
        rstd = 1'b1;
    endtask

    initial begin
        do_reset();

        // Hazard in flight, then reset lands mid-stall.
        drive(1, 0, 0, 7, 1, 0, 0);
        drive(1, 7, 0, 0, 0, 0, 0);
        #3 chk("pre_rst_stall", pc_we, 0);
        do_reset();

`ifndef PIPE_CTRL_FWD_EN
        // r5 written by E: dependent decode stalls through E, M and W.
        drive(1, 0, 0, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 0, 0, 0, 0, 0);
            #3 chk("nofwd_stall_pc", pc_we, 0);
            chk("nofwd_stall_bub", de_bub, 1);
        end
        drive(1, 5, 0, 0, 0, 0, 0);
        #3 chk("nofwd_run_pc", pc_we, 1);
        chk("nofwd_run_bub", de_bub, 0);
        chk("nofwd_cnt3", stall_cycles, 3);
`else
        // Load r5 in E: one load-use stall, then forward from M.
        drive(1, 0, 0, 5, 1, 0, 0);
        drive(1, 0, 5, 0, 0, 0, 0);
        #3 chk("fwd_loaduse_pc", pc_we, 0);
        drive(1, 0, 5, 0, 0, 0, 0);
        #3 chk("fwd_after_pc", pc_we, 1);
        chk("fwd_t_m", fwd_t, 2);
        // ALU producer r6: forwarded from E with no stall.
        drive(1, 0, 0, 6, 0, 0, 0);
        drive(1, 0, 6, 0, 0, 0, 0);
        #3 chk("fwd_alu_pc", pc_we, 1);
        chk("fwd_t_e", fwd_t, 1);
`endif

        // Memory wait on a stalled dependent instruction, then resume stalling.
        do_reset();
        drive(1, 0, 0, 5, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 0, 0, 0, 0, 1);
            #3 chk("mwait_pc", pc_we, 0);
            chk("mwait_mw", mw_we, 0);
            chk("mwait_bub", de_bub, 0);
        end
        drive(1, 5, 0, 0, 0, 0, 0);
        #3 chk("resume_stall_bub", de_bub, 1);
        chk("resume_stall_pc", pc_we, 0);

        // Redirect over a hazard: stall dropped, flush for 1+REDIR_CYC cycles.
        do_reset();
        drive(1, 0, 0, 5, 1, 0, 0);
        drive(1, 5, 0, 0, 0, 1, 0);
        #3 chk("redir_pc", pc_we, 1);
        chk("redir_flush0", fd_flush, 1);
        chk("redir_bub", de_bub, 1);
        for (int i = 0; i < REDIR_CYC; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            #3 chk("redir_flushn", fd_flush, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #3 chk("redir_done", fd_flush, 0);

        // Busy beats redirect; long wait saturates the counter.
        do_reset();
        drive(1, 0, 0, 3, 0, 1, 1);
        #3 chk("busy_over_redir_pc", pc_we, 0);
        chk("busy_over_redir_fl", fd_flush, 0);
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #3 chk("cnt_saturated", stall_cycles, CNT_MAX);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 2);
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
